ivector_multi_queue: RTL and testbench

//  Multi-channel successor of the single-queue indication vector: accepts say(meth,v) requests tagged

---
 rtl/ivector_pkg.sv | 20 ++
 rtl/ivector_chan_fifo.sv | 53 +++++
 rtl/ivector_multi_queue.sv | 124 ++++++++++++
 tb/tb_ivector_multi_queue.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ivector_pkg.sv
// Shared types and helpers for the multi-channel indication vector.
// Holds the message layout, the channel-index width helper and the rule count.
// No ports; imported by ivector_chan_fifo, ivector_multi_queue and the bench.
package ivector_pkg;

  localparam int MSG_METH_W = 32;
  localparam int MSG_V_W    = 32;
  localparam int RULE_COUNT = 1;

  typedef struct packed {
    logic [MSG_METH_W-1:0] meth;
    logic [MSG_V_W-1:0]    v;
  } ivector_msg_t;

  // Width of a channel index; a single-channel build still carries one bit.
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ivector_chan_fifo.sv
// Per-channel message FIFO, DEPTH entries of W bits, strict order; one-cycle enq->first latency.
// Ports: clk, rst_n (sync active-low), enq_ena/enq_data/enq_rdy (enq_rdy = not full),
//        deq_ena/deq_rdy (deq_rdy = not empty), first (head entry, valid while deq_rdy).
module ivector_chan_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enq_ena,
  input  logic [W-1:0] enq_data,
  output logic         enq_rdy,
  input  logic         deq_ena,
  output logic         deq_rdy,
  output logic [W-1:0] first
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         full;
  logic         empty;
  logic         do_enq;
  logic         do_deq;

  // Extra pointer bit distinguishes full from empty when the low bits match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign enq_rdy = ~full;
  assign deq_rdy = ~empty;
  assign first   = mem[rd_ptr[AW-1:0]];

  // Full is judged before this cycle's pop, so a full FIFO refuses a same-cycle write.
  assign do_enq = enq_ena & ~full;
  assign do_deq = deq_ena & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr[AW-1:0]] <= enq_data;
  end

endmodule

// File: rtl/ivector_multi_queue.sv
// Multi-channel indication vector: say(meth,v,chan) is queued per channel and replayed as
// heard(meth,v,chan) through a round-robin respond rule exported as rule_enable/rule_ready.
// Ports: CLK, nRST (sync active-low); say__* request side with per-channel say__RDY;
//        ind_heard__* indication side; rule_enable/rule_ready; heard_count statistics.
// Optional: define IVECTOR_STATS_EN to build the heard_count register; otherwise it reads 0.
module ivector_multi_queue
  import ivector_pkg::*;
#(
  parameter int NCHAN  = 4,
  parameter int DEPTH  = 4,
  parameter int METH_W = 32,
  parameter int V_W    = 32,
  parameter int CNT_W  = 32
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       say__ENA,
  input  logic [chan_w(NCHAN)-1:0]   say_chan,
  input  logic [METH_W-1:0]          say_meth,
  input  logic [V_W-1:0]             say_v,
  output logic [NCHAN-1:0]           say__RDY,
  output logic                       ind_heard__ENA,
  output logic [METH_W-1:0]          ind_heard_meth,
  output logic [V_W-1:0]             ind_heard_v,
  output logic [chan_w(NCHAN)-1:0]   ind_heard_chan,
  input  logic                       ind_heard__RDY,
  input  logic                       rule_enable,
  output logic                       rule_ready,
  output logic [CNT_W-1:0]           heard_count
);

  localparam int CW    = chan_w(NCHAN);
  localparam int MSG_W = METH_W + V_W;

  logic [CW-1:0]    rr;
  logic [CW-1:0]    cand;
  logic             found;
  int               scan_idx;
  logic [NCHAN-1:0] enq;
  logic [NCHAN-1:0] deq;
  logic [NCHAN-1:0] nonempty;
  logic [MSG_W-1:0] head [NCHAN];
  logic [MSG_W-1:0] head_msg;
  logic [RULE_COUNT-1:0] rule_fire;
  logic             fire;

  // Channel select by equality so an out-of-range say_chan matches no FIFO.
  always_comb begin
    enq = '0;
    for (int c = 0; c < NCHAN; c++) begin
      enq[c] = say__ENA && (say_chan == CW'(c)) && say__RDY[c];
    end
  end

  for (genvar g = 0; g < NCHAN; g++) begin : g_chan
    ivector_chan_fifo #(
      .DEPTH (DEPTH),
      .W     (MSG_W)
    ) u_fifo (
      .clk      (CLK),
      .rst_n    (nRST),
      .enq_ena  (enq[g]),
      .enq_data ({say_meth, say_v}),
      .enq_rdy  (say__RDY[g]),
      .deq_ena  (deq[g]),
      .deq_rdy  (nonempty[g]),
      .first    (head[g])
    );
  end

  // Round-robin: first non-empty channel at or above rr, wrapping at NCHAN.
  always_comb begin
    cand     = rr;
    found    = 1'b0;
    scan_idx = 0;
    for (int i = 0; i < NCHAN; i++) begin
      scan_idx = int'(rr) + i;
      if (scan_idx >= NCHAN) scan_idx = scan_idx - NCHAN;
      if (!found && nonempty[scan_idx]) begin
        found = 1'b1;
        cand  = CW'(scan_idx);
      end
    end
  end

  assign rule_ready = (|nonempty) & ind_heard__RDY;
  // One fire bit per exported rule; respond is the only rule here.
  assign rule_fire  = {RULE_COUNT{rule_enable & rule_ready}};
  assign fire       = rule_fire[0];

  always_comb begin
    deq = '0;
    for (int c = 0; c < NCHAN; c++) begin
      deq[c] = fire && (cand == CW'(c));
    end
  end

  assign head_msg       = head[cand];
  assign ind_heard__ENA = fire;
  assign ind_heard_meth = head_msg[MSG_W-1:V_W];
  assign ind_heard_v    = head_msg[V_W-1:0];
  assign ind_heard_chan = cand;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rr <= '0;
    end else if (fire) begin
      rr <= (cand == CW'(NCHAN - 1)) ? '0 : cand + CW'(1);
    end
  end

`ifdef IVECTOR_STATS_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      heard_count <= '0;
    end else if (fire) begin
      heard_count <= heard_count + CNT_W'(1);
    end
  end
`else
  assign heard_count = '0;
`endif

endmodule

// File: tb/tb_ivector_multi_queue.sv
// Directed bench for ivector_multi_queue with NCHAN=4, DEPTH=4, 32-bit payloads.
// Inputs change 1ns after the rising edge; outputs are sampled 2ns after it.
// Expected heard_count follows IVECTOR_STATS_EN (0 when the counter is not built).
module tb_ivector_multi_queue;
  import ivector_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        say_ena;
  logic [1:0]  say_chan;
  logic [31:0] say_meth;
  logic [31:0] say_v;
  logic [3:0]  say_rdy;
  logic        heard_ena;
  logic [31:0] heard_meth;
  logic [31:0] heard_v;
  logic [1:0]  heard_chan;
  logic        heard_rdy;
  logic        rule_enable;
  logic        rule_ready;
  logic [31:0] heard_count;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  always #5 CLK = ~CLK;

  ivector_multi_queue #(
    .NCHAN(4), .DEPTH(4), .METH_W(32), .V_W(32), .CNT_W(32)
  ) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .say__ENA       (say_ena),
    .say_chan       (say_chan),
    .say_meth       (say_meth),
    .say_v          (say_v),
    .say__RDY       (say_rdy),
    .ind_heard__ENA (heard_ena),
    .ind_heard_meth (heard_meth),
    .ind_heard_v    (heard_v),
    .ind_heard_chan (heard_chan),
    .ind_heard__RDY (heard_rdy),
    .rule_enable    (rule_enable),
    .rule_ready     (rule_ready),
    .heard_count    (heard_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] cnt_exp();
`ifdef IVECTOR_STATS_EN
    return 64'(exp_cnt);
`else
    return 64'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    say_ena = 1'b0;
    rule_enable = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic say(input int ch, input logic [31:0] m, input logic [31:0] v);
    say_chan = ch[1:0];
    say_meth = m;
    say_v    = v;
    say_ena  = 1'b1;
    tick();
    say_ena  = 1'b0;
  endtask

  // Expects a delivery this cycle (rule_enable already high), then advances one edge.
  task automatic expect_heard(input string tag, input int ch, input logic [31:0] m,
                              input logic [31:0] v);
    ivector_msg_t msg;
    msg.meth = m;
    msg.v    = v;
    #1;
    chk({tag, "_ena"}, 64'(heard_ena), 64'd1);
    chk({tag, "_chan"}, 64'(heard_chan), 64'(ch));
    chk({tag, "_msg"}, {heard_meth, heard_v}, 64'(msg));
    tick();
    exp_cnt++;
  endtask

  initial begin
    nRST = 1'b0; say_ena = 1'b0; say_chan = '0; say_meth = '0; say_v = '0;
    heard_rdy = 1'b1; rule_enable = 1'b0;
    do_reset();
    #1;
    chk("rst_rdy", 64'(say_rdy), 64'hF);
    chk("rst_ena", 64'(heard_ena), 64'd0);
    chk("rst_ready", 64'(rule_ready), 64'd0);
    chk("rst_cnt", 64'(heard_count), 64'd0);

    // 1: single message on ch2, no bypass
    rule_enable = 1'b1;
    say_chan = 2'd2; say_meth = 32'h11; say_v = 32'h22; say_ena = 1'b1;
    #1;
    chk("t1_nobypass", 64'(heard_ena), 64'd0);
    tick();
    say_ena = 1'b0;
    expect_heard("t1", 2, 32'h11, 32'h22);
    #1;
    chk("t1_cnt", 64'(heard_count), cnt_exp());
    chk("t1_idle", 64'(heard_ena), 64'd0);

    // 2: fill ch0, overflow dropped, drain in order
    rule_enable = 1'b0;
    for (int i = 0; i < 4; i++) say(0, 32'hA0 + i, 32'hB0 + i);
    #1;
    chk("t2_full_rdy", 64'(say_rdy), 64'hE);
    say(0, 32'hEE, 32'hEF);
    #1;
    chk("t2_drop_rdy", 64'(say_rdy), 64'hE);
    rule_enable = 1'b1;
    for (int i = 0; i < 4; i++) expect_heard("t2_drain", 0, 32'hA0 + i, 32'hB0 + i);
    #1;
    chk("t2_empty_ena", 64'(heard_ena), 64'd0);
    chk("t2_empty_ready", 64'(rule_ready), 64'd0);
    chk("t2_cnt", 64'(heard_count), cnt_exp());
    rule_enable = 1'b0;

    // 3: round robin over all channels from rr=0
    do_reset();
    for (int c = 0; c < 4; c++) say(c, 32'h30 + c, 32'h40 + c);
    rule_enable = 1'b1;
    for (int c = 0; c < 4; c++) expect_heard("t3_rr", c, 32'h30 + c, 32'h40 + c);
    // rr back at 0: ch0 must win over ch1 even though ch1 was queued first
    rule_enable = 1'b0;
    say(1, 32'h61, 32'h71);
    say(0, 32'h60, 32'h70);
    rule_enable = 1'b1;
    expect_heard("t3_wrap0", 0, 32'h60, 32'h70);
    expect_heard("t3_wrap1", 1, 32'h61, 32'h71);
    rule_enable = 1'b0;

    // 4: sink backpressure
    say(2, 32'h44, 32'h55);
    heard_rdy = 1'b0;
    rule_enable = 1'b1;
    #1;
    chk("t4_ready_low", 64'(rule_ready), 64'd0);
    chk("t4_no_ena", 64'(heard_ena), 64'd0);
    tick();
    tick();
    #1;
    chk("t4_still_no_ena", 64'(heard_ena), 64'd0);
    chk("t4_say_rdy", 64'(say_rdy), 64'hF);
    heard_rdy = 1'b1;
    expect_heard("t4_resume", 2, 32'h44, 32'h55);
    #1;
    chk("t4_cnt", 64'(heard_count), cnt_exp());
    rule_enable = 1'b0;

    // 5: full ch1 with same-cycle say and pop
    for (int i = 0; i < 4; i++) say(1, 32'h50 + i, 32'h90 + i);
    say_chan = 2'd1; say_meth = 32'h5F; say_v = 32'h9F; say_ena = 1'b1;
    rule_enable = 1'b1;
    #1;
    chk("t5_full_rdy", 64'(say_rdy), 64'hD);
    expect_heard("t5_pop", 1, 32'h50, 32'h90);
    say_ena = 1'b0;
    #1;
    chk("t5_occ3_rdy", 64'(say_rdy), 64'hF);
    for (int i = 1; i < 4; i++) expect_heard("t5_rest", 1, 32'h50 + i, 32'h90 + i);
    #1;
    chk("t5_empty_ena", 64'(heard_ena), 64'd0);
    chk("t5_cnt", 64'(heard_count), cnt_exp());
    rule_enable = 1'b0;

    // 6: reset discards queued entries
    say(0, 32'h1, 32'h1);
    say(3, 32'h2, 32'h2);
    say(3, 32'h3, 32'h3);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    exp_cnt = 0;
    rule_enable = 1'b1;
    #1;
    chk("t6_rdy", 64'(say_rdy), 64'hF);
    chk("t6_ready", 64'(rule_ready), 64'd0);
    chk("t6_ena", 64'(heard_ena), 64'd0);
    chk("t6_cnt", 64'(heard_count), 64'd0);
    tick();
    #1;
    chk("t6_ready_later", 64'(rule_ready), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
